// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit.
// Shift-add multiply, restoring divide, start/busy/done handshake.
module muldiv_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              flush,
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  localparam int CW = $clog2(DATA_W);
  localparam int W2 = 2 * DATA_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [CW-1:0]       r_cnt;
  logic [2:0]          r_op;
  logic [DATA_W-1:0]   r_opnd;
  logic [W2-1:0]       r_prod;
  logic                r_neg_prod;
  logic                r_neg_rem;
  logic [DATA_W-1:0]   r_result;

  logic                w_accept;
  logic                w_is_div;
  logic                w_sgn_a;
  logic                w_sgn_b;
  logic                w_sa;
  logic                w_sb;
  logic [DATA_W-1:0]   w_abs_a;
  logic [DATA_W-1:0]   w_abs_b;
  logic [DATA_W-1:0]   w_min;
  logic                w_dz;
  logic                w_ovf;
  logic                w_special;
  logic [DATA_W-1:0]   w_spec_res;
  logic                w_last;
  logic [DATA_W:0]     w_msum;
  logic [DATA_W:0]     w_dsh;
  logic [DATA_W+1:0]   w_ddiff;
  logic                w_dok;
  logic [W2-1:0]       w_mul_nxt;
  logic [W2-1:0]       w_div_nxt;
  logic [W2-1:0]       w_prod_s;
  logic [DATA_W-1:0]   w_quo;
  logic [DATA_W-1:0]   w_rem;
  logic [DATA_W-1:0]   w_fix_res;

  assign w_accept  = (r_state == S_IDLE) && start;
  assign w_is_div  = funct3[2];
  assign w_sgn_a   = funct3[2] ? ~funct3[0]
                   : (funct3[1] ^ funct3[0]);
  assign w_sgn_b   = funct3[2] ? ~funct3[0]
                   : (funct3[1:0] == 2'b01);
  assign w_sa      = w_sgn_a & op_a[DATA_W-1];
  assign w_sb      = w_sgn_b & op_b[DATA_W-1];
  assign w_abs_a   = w_sa ? -op_a : op_a;
  assign w_abs_b   = w_sb ? -op_b : op_b;
  assign w_min     = {1'b1, {(DATA_W-1){1'b0}}};
  assign w_dz      = w_is_div && (op_b == '0);
  assign w_ovf     = w_is_div && !funct3[0]
                   && (op_a == w_min)
                   && (op_b == '1);
  assign w_special = w_dz | w_ovf;
  assign w_last    = (r_cnt == CW'(DATA_W - 1));

  // Divide-by-zero and signed overflow answers
  always_comb begin
    w_spec_res = op_a;
    if (w_dz) begin
      w_spec_res = funct3[1] ? op_a : '1;
    end else begin
      w_spec_res = funct3[1] ? '0 : op_a;
    end
  end

  assign w_msum = {1'b0, r_prod[W2-1:DATA_W]}
                + (r_prod[0] ? {1'b0, r_opnd}
                             : '0);
  assign w_mul_nxt = {w_msum, r_prod[DATA_W-1:1]};

  assign w_dsh   = r_prod[W2-1:DATA_W-1];
  assign w_ddiff = {1'b0, w_dsh} - {2'b00, r_opnd};
  assign w_dok   = ~w_ddiff[DATA_W+1];
  assign w_div_nxt = {
    w_dok ? w_ddiff[DATA_W-1:0] : w_dsh[DATA_W-1:0],
    r_prod[DATA_W-2:0],
    w_dok
  };

  assign w_prod_s = r_neg_prod ? -r_prod : r_prod;
  assign w_quo = r_neg_prod ? -r_prod[DATA_W-1:0]
                            : r_prod[DATA_W-1:0];
  assign w_rem = r_neg_rem ? -r_prod[W2-1:DATA_W]
                           : r_prod[W2-1:DATA_W];

  // Final sign fix and half/quotient/remainder select
  always_comb begin
    w_fix_res = '0;
    unique case (1'b1)
      (r_op == 3'b000): w_fix_res = w_prod_s[DATA_W-1:0];
      (r_op[2] == 1'b0 && r_op != 3'b000):
        w_fix_res = w_prod_s[W2-1:DATA_W];
      (r_op[2:1] == 2'b10): w_fix_res = w_quo;
      (r_op[2:1] == 2'b11): w_fix_res = w_rem;
      default: w_fix_res = '0;
    endcase
  end

  // Next-state logic; flush wins over everything
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (start) w_next = w_special ? S_DONE : S_CALC;
      S_CALC: if (w_last) w_next = S_FIX;
      S_FIX:  w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (flush) w_next = S_IDLE;
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Operand latch, iteration datapath and result register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt      <= '0;
      r_op       <= '0;
      r_opnd     <= '0;
      r_prod     <= '0;
      r_neg_prod <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_result   <= '0;
    end else if (!flush) begin
      if (w_accept) begin
        r_op       <= funct3;
        r_cnt      <= '0;
        r_neg_prod <= w_sa ^ w_sb;
        r_neg_rem  <= w_sa;
        r_opnd     <= w_is_div ? w_abs_b : w_abs_a;
        r_prod     <= {{DATA_W{1'b0}},
                       w_is_div ? w_abs_a : w_abs_b};
        if (w_special) r_result <= w_spec_res;
      end else if (r_state == S_CALC) begin
        r_cnt  <= r_cnt + 1'b1;
        r_prod <= r_op[2] ? w_div_nxt : w_mul_nxt;
      end else if (r_state == S_FIX) begin
        r_result <= w_fix_res;
      end
    end
  end

  assign busy   = (r_state != S_IDLE);
  assign done   = (r_state == S_DONE);
  assign result = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed and random ops
// against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        flush;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  logic        start16;
  logic        flush16;
  logic [2:0]  f16;
  logic [15:0] a16;
  logic [15:0] b16;
  logic        busy16;
  logic        done16;
  logic [15:0] res16;

  int n_cmp;
  int n_err;
  logic [31:0] last_exp;

  muldiv_unit #(.DATA_W(32)) u_dut (
    .clk(clk), .reset(rst_n), .start(start),
    .flush(flush), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .busy(busy),
    .done(done), .result(result)
  );

  muldiv_unit #(.DATA_W(16)) u_dut16 (
    .clk(clk), .reset(rst_n), .start(start16),
    .flush(flush16), .funct3(f16),
    .op_a(a16), .op_b(b16), .busy(busy16),
    .done(done16), .result(res16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: observed no end, expected finish");
    $fatal(1, "watchdog");
  end

  localparam logic [31:0] MIN = 32'h8000_0000;

  function automatic logic [31:0] model(
    input logic [2:0] f, input logic [31:0] a,
    input logic [31:0] b);
    longint sa, sb, ua, ub, q;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    p = '0;
    q = 0;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MIN && b == 32'hFFFF_FFFF) return a;
        q = sa / sb; return q[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        q = ua / ub; return q[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == MIN && b == 32'hFFFF_FFFF) return 0;
        q = sa % sb; return q[31:0];
      end
      default: begin
        if (b == 0) return a;
        q = ua % ub; return q[31:0];
      end
    endcase
  endfunction

  function automatic bit is_special(
    input logic [2:0] f, input logic [31:0] a,
    input logic [31:0] b);
    if (!f[2]) return 1'b0;
    if (b == 0) return 1'b1;
    return !f[0] && a == MIN && b == 32'hFFFF_FFFF;
  endfunction

  task automatic chk(input string tag,
    input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] f,
    input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; funct3 = f; op_a = a; op_b = b;
    @(posedge clk);
  endtask

  task automatic wait_done(output int lat,
    input bit chk_busy);
    lat = -1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start  = 1'b0;
        funct3 = 3'($urandom);
        op_a   = $urandom;
        op_b   = $urandom;
      end
      if (chk_busy) chk("busy_hi", {31'd0, busy}, 32'd1);
      if (done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic do_op(input string tag,
    input logic [2:0] f, input logic [31:0] a,
    input logic [31:0] b);
    int lat;
    logic [31:0] exp;
    exp = model(f, a, b);
    issue(f, a, b);
    wait_done(lat, 1'b0);
    chk({tag, "_res"}, result, exp);
    chk({tag, "_lat"}, lat,
        is_special(f, a, b) ? 32'd1 : 32'd34);
    last_exp = exp;
  endtask

  initial begin
    int lat;
    int d1;
    int d2;
    int seen;
    logic [2:0]  rf;
    logic [31:0] ra;
    logic [31:0] rb;
    n_cmp = 0; n_err = 0; last_exp = '0;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0;
    funct3 = '0; op_a = '0; op_b = '0;
    start16 = 1'b0; flush16 = 1'b0;
    f16 = '0; a16 = '0; b16 = '0;

    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    rst_n = 1'b1;

    do_op("mul", 3'b000, 32'hFFFF_FFFE, 32'd3);
    chk("mul_dir", result, 32'hFFFF_FFFA);
    do_op("mulh", 3'b001, 32'hFFFF_FFFE, 32'd3);
    chk("mulh_dir", result, 32'hFFFF_FFFF);
    do_op("mulhu", 3'b011, 32'hFFFF_FFFE, 32'd3);
    chk("mulhu_dir", result, 32'h0000_0002);

    issue(3'b010, MIN, 32'hFFFF_FFFF);
    wait_done(lat, 1'b1);
    chk("mulhsu_lat", lat, 32'd34);
    chk("mulhsu_dir", result, 32'h8000_0000);
    @(negedge clk);
    chk("post_busy", {31'd0, busy}, 32'd0);
    chk("post_done", {31'd0, done}, 32'd0);

    do_op("div", 3'b100, 32'hFFFF_FFF9, 32'd2);
    chk("div_dir", result, 32'hFFFF_FFFD);
    do_op("rem", 3'b110, 32'hFFFF_FFF9, 32'd2);
    chk("rem_dir", result, 32'hFFFF_FFFF);
    do_op("divu", 3'b101, 32'hFFFF_FFF9, 32'd2);
    chk("divu_dir", result, 32'h7FFF_FFFC);
    do_op("remu", 3'b111, 32'hFFFF_FFF9, 32'd2);
    chk("remu_dir", result, 32'h0000_0001);

    do_op("divu0", 3'b101, 32'h1234_5678, 32'd0);
    chk("divu0_dir", result, 32'hFFFF_FFFF);
    do_op("rem0", 3'b110, 32'h1234_5678, 32'd0);
    chk("rem0_dir", result, 32'h1234_5678);
    do_op("divovf", 3'b100, MIN, 32'hFFFF_FFFF);
    chk("divovf_dir", result, MIN);
    do_op("removf", 3'b110, MIN, 32'hFFFF_FFFF);
    chk("removf_dir", result, 32'd0);

    for (int i = 0; i < 48; i++) begin
      rf = 3'($urandom);
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(7) == 0) ra = MIN;
      case ($urandom_range(7))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'($urandom_range(9));
        default: ;
      endcase
      do_op("rnd", rf, ra, rb);
    end

    issue(3'b100, 32'd1000, 32'd7);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (c == 10) flush = 1'b1;
    end
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_done", {31'd0, done}, 32'd0);
    chk("flush_res", result, last_exp);
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("flush_nodone", seen, 32'd0);

    @(negedge clk);
    flush = 1'b1; start = 1'b1;
    funct3 = 3'b000; op_a = 32'd2; op_b = 32'd2;
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    chk("flush_prio", {31'd0, busy}, 32'd0);

    issue(3'b000, 32'd77, 32'd88);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_done", {31'd0, done}, 32'd0);
    chk("mrst_res", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op("mul35", 3'b000, 32'd3, 32'd5);
    chk("mul35_dir", result, 32'd15);

    @(negedge clk);
    start = 1'b1; funct3 = 3'b110;
    op_a = 32'hDEAD_BEEF; op_b = 32'd1234;
    @(posedge clk);
    d1 = -1; d2 = -1;
    for (int c = 1; c <= 90; c++) begin
      @(negedge clk);
      if (done) begin
        if (d1 < 0) begin
          d1 = c;
          chk("b2b_res1", result,
              model(3'b110, 32'hDEAD_BEEF, 32'd1234));
        end else begin
          d2 = c;
          chk("b2b_res2", result,
              model(3'b110, 32'hDEAD_BEEF, 32'd1234));
          break;
        end
      end
    end
    start = 1'b0;
    chk("b2b_d1", d1, 32'd34);
    chk("b2b_d2", d2, 32'd69);

    @(negedge clk);
    start16 = 1'b1; f16 = 3'b001;
    a16 = 16'h8000; b16 = 16'h0002;
    @(posedge clk);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start16 = 1'b0;
        a16 = 16'h1111; b16 = 16'h2222;
      end
      if (done16) begin
        lat = c;
        break;
      end
    end
    chk("w16_res", {16'd0, res16}, 32'h0000_FFFF);
    chk("w16_lat", lat, 32'd18);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
